// File: rtl/dcache_wb_pkg.sv
// -----------------------------------------------------------------------------
// dcache_wb_pkg
// Shared types and constants for the data-cache line writeback engine.
//   wb_state_e    : writeback FSM states (ST_AW_W only reachable when the
//                   DCACHE_WB_PARALLEL_AW_EN macro is defined)
//   dcache_line_t : one cache line as four 32-bit words, word 0 in bits[31:0]
//   WB_BEATS      : AXI beats per line
//   AXI_LEN_WB / AXI_SIZE_WORD : AXI burst length and beat size for a line
//   Dcache_index_bits : default data-RAM index width shared with the cache
// -----------------------------------------------------------------------------
package dcache_wb_pkg;

  localparam int Dcache_index_bits = 6;

  localparam int WB_BEATS = 4;

  localparam logic [7:0] AXI_LEN_WB    = 8'(WB_BEATS - 1);
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

  typedef logic [WB_BEATS-1:0][31:0] dcache_line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_AW_W,
    ST_B
  } wb_state_e;

endpackage

// File: rtl/dcache_wb_linebuf.sv
// -----------------------------------------------------------------------------
// dcache_wb_linebuf
// Captures one cache line when a writeback is accepted and presents the word
// selected by the current beat.
//   clk    : clock
//   load_i : capture line_i on this rising edge
//   line_i : line read from the data RAM (combinational read)
//   beat_i : beat index, 0 selects bits[31:0]
//   word_o : selected 32-bit word
// -----------------------------------------------------------------------------
module dcache_wb_linebuf
  import dcache_wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     load_i,
  input  logic [WB_BEATS*32-1:0]   line_i,
  input  logic [1:0]               beat_i,
  output logic [31:0]              word_o
);

  dcache_line_t line_q;

  // NOTE: pure data storage has no reset; it is always loaded at acceptance
  // before any beat reads it, so a reset would only cost area and fan-out.
  always_ff @(posedge clk) begin
    if (load_i) begin
      line_q <= line_i;
    end
  end

  assign word_o = line_q[beat_i];

endmodule

// File: rtl/dcache_wb.sv
// -----------------------------------------------------------------------------
// dcache_wb
// Writes one dirty cache line back to memory as a 4-beat AXI INCR burst.
// The line is read from the data RAM in the accepting cycle (zero latency)
// and held locally, so the RAM may be rewritten while the burst is running.
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   req_valid / req_ready  : writeback request handshake (ready only in IDLE)
//   req_index, req_paddr   : line index and line base address (bits[3:0] ignored)
//   ram_addr/strobe/rdata  : data-RAM read port (index follows req_index)
//   aw_*                   : AXI write address channel
//   w_*                    : AXI write data channel
//   b_valid / b_ready      : AXI write response (response code ignored)
//   done                   : one-cycle pulse after the write response
//
// Configuration
//   DCACHE_WB_PARALLEL_AW_EN : when defined, AW and W are offered together in
//                              ST_AW_W and complete independently; otherwise
//                              AW is accepted before any W beat is offered.
// -----------------------------------------------------------------------------
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int INDEX_WIDTH = Dcache_index_bits,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [31:0]            req_paddr,
  output logic [INDEX_WIDTH-1:0] ram_addr,
  output logic [15:0]            ram_strobe,
  input  logic [LINE_WIDTH-1:0]  ram_rdata,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [31:0]            aw_addr,
  output logic [7:0]             aw_len,
  output logic [2:0]             aw_size,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [31:0]            w_data,
  output logic [3:0]             w_strb,
  output logic                   w_last,
  input  logic                   b_valid,
  output logic                   b_ready,
  output logic                   done
);

  wb_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  beat_q, beat_d;
  logic        done_q, done_d;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic w_last_hs;
  logic b_hs;

  // Low address bits are an offset inside the line and are never used.
  logic unused_paddr_bits;
  assign unused_paddr_bits = ^req_paddr[3:0];

  assign accept    = req_valid & req_ready;
  assign aw_hs     = aw_valid & aw_ready;
  assign w_hs      = w_valid & w_ready;
  assign w_last_hs = w_hs & w_last;
  assign b_hs      = b_valid & b_ready;

  // Read-only client of the data RAM.
  assign ram_addr   = req_index;
  assign ram_strobe = '0;

  // ---------------------------------------------------------------------------
  // Line buffer: captured on acceptance, word selected by the beat counter.
  // ---------------------------------------------------------------------------
  dcache_wb_linebuf u_linebuf (
    .clk    (clk),
    .load_i (accept),
    .line_i (ram_rdata),
    .beat_i (beat_q),
    .word_o (w_data)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DCACHE_WB_PARALLEL_AW_EN
  // Sticky per-channel completion flags for the combined AW_W state.
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  assign aw_done_d = accept ? 1'b0 : (aw_done_q | aw_hs);
  assign w_done_d  = accept ? 1'b0 : (w_done_q | w_last_hs);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef DCACHE_WB_PARALLEL_AW_EN
          state_d = ST_AW_W;
`else
          state_d = ST_AW;
`endif
        end
      end
      ST_AW: begin
        if (aw_hs) state_d = ST_W;
      end
      ST_W: begin
        if (w_last_hs) state_d = ST_B;
      end
`ifdef DCACHE_WB_PARALLEL_AW_EN
      ST_AW_W: begin
        // Either channel may finish in the same cycle the other already has.
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
`endif
      ST_B: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_AW:   aw_valid  = 1'b1;
      ST_W:    w_valid   = 1'b1;
`ifdef DCACHE_WB_PARALLEL_AW_EN
      ST_AW_W: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
      end
`endif
      ST_B:    b_ready   = 1'b1;
      default: ;
    endcase
  end

  // Payload is held in registers, so it is stable while valid waits on ready.
  assign aw_addr = addr_q;
  assign aw_len  = AXI_LEN_WB;
  assign aw_size = AXI_SIZE_WORD;
  assign w_strb  = 4'hF;
  assign w_last  = w_valid & (beat_q == 2'(WB_BEATS - 1));
  assign done    = done_q;

  // ---------------------------------------------------------------------------
  // Datapath registers: line address, beat counter, completion pulse
  // ---------------------------------------------------------------------------
  assign addr_d = accept ? {req_paddr[31:4], 4'b0000} : addr_q;
  // The counter wraps to 0 after the last beat, ready for the next line.
  assign beat_d = accept ? 2'd0 : (w_hs ? beat_q + 2'd1 : beat_q);
  assign done_d = b_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
      beat_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// -----------------------------------------------------------------------------
// tb_dcache_wb
// Self-checking bench for dcache_wb. A transaction-level model tracks whether
// a writeback is in flight and which channels have completed; expected AW
// addresses and W beats are queued at acceptance from a behavioural RAM and
// compared by a negedge monitor whenever the DUT presents them. A randomised
// AXI slave drives the ready/response inputs.
// -----------------------------------------------------------------------------
module tb_dcache_wb;

  localparam int IW = 6;

  logic          clk;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_index;
  logic [31:0]   req_paddr;
  logic [IW-1:0] ram_addr;
  logic [15:0]   ram_strobe;
  logic [127:0]  ram_rdata;
  logic          aw_valid, aw_ready;
  logic [31:0]   aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic          w_valid, w_ready;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          w_last;
  logic          b_valid, b_ready;
  logic          done;

  dcache_wb #(.INDEX_WIDTH(IW), .LINE_WIDTH(128)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .req_paddr  (req_paddr),
    .ram_addr   (ram_addr),
    .ram_strobe (ram_strobe),
    .ram_rdata  (ram_rdata),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .aw_addr    (aw_addr),
    .aw_len     (aw_len),
    .aw_size    (aw_size),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_strb     (w_strb),
    .w_last     (w_last),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data RAM, combinational read.
  logic [127:0] mem [64];
  assign ram_rdata = mem[ram_addr];

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } wbeat_t;

  logic [31:0] exp_aw[$];
  wbeat_t      exp_w[$];

  // Transaction model state (written only by the monitor).
  logic busy     = 1'b0;
  logic aw_done  = 1'b0;
  logic w_done   = 1'b0;
  logic done_exp = 1'b0;
  int   beats    = 0;
  int   acc_cnt  = 0;
  int   b_cnt    = 0;
  int   done_cnt = 0;
  int   aw_beats_at = 0;

  // Slave knobs (written only by the main stimulus).
  int aw_pct = 100, w_pct = 100, b_pct = 100;
  int aw_delay = 0;
  int w_stall_beat = -1, w_stall_len = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: checks on the falling edge, then advances the model with the
  // handshakes that will complete on the next rising edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic   exp_wv;
    logic   [127:0] line;
    wbeat_t wb;

    if (!resetn) begin
      busy = 1'b0; aw_done = 1'b0; w_done = 1'b0; beats = 0; done_exp = 1'b0;
      exp_aw.delete();
      exp_w.delete();
    end

`ifdef DCACHE_WB_PARALLEL_AW_EN
    exp_wv = busy && !w_done;
`else
    exp_wv = busy && aw_done && !w_done;
`endif

    check("req_ready",  req_ready,  !busy);
    check("aw_valid",   aw_valid,   busy && !aw_done);
    check("w_valid",    w_valid,    exp_wv);
    check("b_ready",    b_ready,    busy && aw_done && w_done);
    check("done",       done,       done_exp);
    check("ram_addr",   ram_addr,   req_index);
    check("ram_strobe", ram_strobe, 16'h0000);

    if (aw_valid) begin
      if (exp_aw.size() == 0) check("aw_unexpected", aw_valid, 1'b0);
      else begin
        check("aw_addr", aw_addr, exp_aw[0]);
        check("aw_len",  aw_len,  8'd3);
        check("aw_size", aw_size, 3'b010);
      end
    end

    if (w_valid) begin
      if (exp_w.size() == 0) check("w_unexpected", w_valid, 1'b0);
      else begin
        check("w_data", w_data, exp_w[0].data);
        check("w_last", w_last, exp_w[0].last);
        check("w_strb", w_strb, 4'hF);
      end
    end else begin
      check("w_last_idle", w_last, 1'b0);
    end

    if (done) done_cnt++;
    done_exp = 1'b0;

    if (resetn) begin
      if (req_valid && req_ready) begin
        busy = 1'b1; aw_done = 1'b0; w_done = 1'b0; beats = 0;
        acc_cnt++;
        exp_aw.push_back({req_paddr[31:4], 4'h0});
        line = mem[req_index];
        for (int i = 0; i < 4; i++) begin
          wb.data = line[32*i +: 32];
          wb.last = (i == 3);
          exp_w.push_back(wb);
        end
      end
      if (aw_valid && aw_ready) begin
        aw_done = 1'b1;
        aw_beats_at = beats;
        if (exp_aw.size() > 0) void'(exp_aw.pop_front());
      end
      if (w_valid && w_ready) begin
        beats++;
        if (beats == 4) w_done = 1'b1;
        if (exp_w.size() > 0) void'(exp_w.pop_front());
      end
      if (b_valid && b_ready) begin
        busy = 1'b0;
        done_exp = 1'b1;
        b_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AXI slave: randomised readiness, directed AW delay and W stall, response
  // offered once the model says the whole burst has been transferred.
  // ---------------------------------------------------------------------------
  initial begin
    int last_acc   = 0;
    int stall_used = 0;
    int aw_wait    = 0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (acc_cnt != last_acc) begin
        last_acc   = acc_cnt;
        stall_used = 0;
      end
      if (aw_valid) begin
        if (aw_wait < aw_delay) begin
          aw_ready = 1'b0;
          aw_wait++;
        end else aw_ready = pick(aw_pct);
      end else begin
        aw_wait  = 0;
        aw_ready = pick(aw_pct);
      end
      if (w_valid && beats == w_stall_beat && stall_used < w_stall_len) begin
        w_ready = 1'b0;
        stall_used++;
      end else w_ready = pick(w_pct);
      b_valid = resetn && busy && aw_done && w_done && (b_valid || pick(b_pct));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_req(input logic [IW-1:0] idx, input logic [31:0] pa);
    int start = acc_cnt;
    int t = 0;
    req_index = idx;
    req_paddr = pa;
    req_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      t++;
    end while (acc_cnt == start && t < 300);
    check("req_accepted", acc_cnt - start, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("txn_complete", busy, 1'b0);
    cycles(1);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d0;
    int t;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_index = '0;
    req_paddr = '0;
    for (int i = 0; i < 64; i++) mem[i] = rand_line();

    cycles(3);
    resetn = 1'b1;
    cycles(2);

    // Basic line writeback with known words.
    mem[5] = 128'h44444444_33333333_22222222_11111111;
    d0 = done_cnt;
    do_req(6'd5, 32'h1FC0_0A3C);
    wait_idle();
    check("basic_done_count", done_cnt - d0, 1);

    // w_ready stalled three cycles on beat 2.
    w_stall_beat = 2; w_stall_len = 3;
    do_req(6'd5, 32'h0000_1234);
    wait_idle();
    w_stall_beat = -1; w_stall_len = 0;

    // RAM rewritten right after acceptance; the captured line must go out.
    w_pct = 50;
    do_req(6'd5, 32'h8000_0040);
    mem[5] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    wait_idle();
    w_pct = 100;

    // Second request held during a burst is taken only once IDLE returns.
    b_pct = 30;
    d0 = done_cnt;
    do_req(6'd9, 32'h1111_2220);
    do_req(6'd12, 32'h3333_4440);
    check("second_accept_after_done", done_cnt - d0, 1);
    wait_idle();
    b_pct = 100;

    // Reset while beat 1 is on the bus: burst abandoned, no done.
    w_pct = 30;
    d0 = done_cnt;
    do_req(6'd7, 32'h0BAD_0000);
    t = 0;
    while (beats != 1 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_beat1", beats, 1);
    resetn = 1'b0;
    cycles(2);
    resetn = 1'b1;
    cycles(8);
    check("no_done_after_reset", done_cnt - d0, 0);
    w_pct = 100;

    // AW held off five cycles while W is always ready.
    aw_delay = 5;
    do_req(6'd20, 32'hCAFE_0100);
    wait_idle();
`ifdef DCACHE_WB_PARALLEL_AW_EN
    check("beats_before_aw", aw_beats_at, 4);
`else
    check("beats_before_aw", aw_beats_at, 0);
`endif
    aw_delay = 0;

    // Randomised traffic.
    for (int n = 0; n < 30; n++) begin
      logic [IW-1:0] idx;
      idx          = IW'($urandom_range(63, 0));
      aw_pct       = $urandom_range(100, 30);
      w_pct        = $urandom_range(100, 30);
      b_pct        = $urandom_range(100, 30);
      aw_delay     = $urandom_range(3, 0);
      w_stall_beat = $urandom_range(5, 0);
      w_stall_len  = $urandom_range(4, 0);
      if ($urandom_range(1, 0) == 1) mem[idx] = rand_line();
      do_req(idx, $urandom);
      if ($urandom_range(2, 0) == 0) mem[idx] = rand_line();
      if ($urandom_range(1, 0) == 1) wait_idle();
    end
    wait_idle();

    check("aw_queue_drained", exp_aw.size(), 0);
    check("w_queue_drained",  exp_w.size(),  0);
    check("done_matches_b",   done_cnt,      b_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default Dcache_index_bits, data-RAM index width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, line width in bits; fixed at 4 x 32-bit words.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1  writeback request handshake.
REQ-006 SHALL have ports req_index in INDEX_WIDTH / req_paddr in 32  line index; line base physical address, bits[3:0] ignored.
REQ-007 SHALL have ports ram_addr out INDEX_WIDTH / ram_strobe out 16 / ram_rdata in LINE_WIDTH  data-RAM read port, combinational read.
REQ-008 SHALL have ports aw_valid out 1, aw_ready in 1, aw_addr out 32, aw_len out 8, aw_size out 3  AXI write address.
REQ-009 SHALL have ports w_valid out 1, w_ready in 1, w_data out 32, w_strb out 4, w_last out 1  AXI write data.
REQ-010 SHALL have ports b_valid in 1, b_ready out 1, done out 1  AXI response; done is a one-cycle completion pulse.

Function
REQ-011 SHALL drive ram_addr = req_index at all times; ram_strobe SHALL be constant 0 (read-only client).
REQ-012 SHALL assert req_ready only in IDLE; on req_valid & req_ready it SHALL capture ram_rdata into a 128-bit line buffer that same edge (zero read latency) and latch {req_paddr[31:4],4'b0}.
REQ-013 SHALL implement states IDLE -> AW -> W -> B -> IDLE.
REQ-014 AW: aw_valid=1, aw_addr=latched address, aw_len=8'd3, aw_size=3'b010; leave on aw_ready.
REQ-015 W: w_valid=1, w_strb=4'hF, w_data=buffer word[beat], beat 0 = bits[31:0]; 2-bit beat counter increments on w_valid & w_ready.
REQ-016 w_last SHALL be 1 exactly when beat==3; handshake with w_last SHALL move to B.
REQ-017 B: b_ready=1; on b_valid SHALL pulse done for one cycle and return to IDLE; b_resp is ignored.
REQ-018 aw_valid/w_valid SHALL stay asserted with stable payload until accepted (AXI stability).
REQ-019 w_ready stalls of any length SHALL hold beat and w_data unchanged.
REQ-020 A request arriving while busy SHALL wait; no queuing beyond the handshake.
REQ-021 Line buffer SHALL not change between acceptance and done, even if the RAM contents change.

Reset
REQ-022 resetn low SHALL immediately force IDLE, beat=0, req_ready=1, aw_valid=0, w_valid=0, w_last=0, b_ready=0, done=0.
REQ-023 Reset mid-burst SHALL abandon the transaction; no done pulse follows.

Configuration
REQ-024 Macro DCACHE_WB_PARALLEL_AW_EN: defined -> after acceptance aw_valid and w_valid assert together in a combined AW_W state; AW and W handshakes complete independently, B entered once both done.
REQ-025 Undefined -> strictly serial AW then W per REQ-013; W never valid before AW accepted.

Structure
REQ-026 Shared package SHALL hold the state enum, dcache_line_t (4 x 32 words), WB_BEATS=4 and the AXI size/len constants; Dcache_index_bits stays in common.svh.
REQ-027 One sub-module is natural: dcache_wb_linebuf (128-bit capture register plus beat mux); the rest SHALL stay in dcache_wb.

Verification
REQ-028 Line 0x44444444_33333333_22222222_11111111 at index 5, paddr 0x1FC0_0A3C -> aw_addr 0x1FC0_0A30, aw_len 3, W beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, w_last on 4th only, done one cycle after b_valid.
REQ-029 w_ready low 3 cycles during beat 2 -> w_data holds 0x33333333, no beat skipped or repeated.
REQ-030 RAM rewritten at index 5 immediately after acceptance -> original line data still emitted.
REQ-031 Second req_valid held during burst -> req_ready low until after done, then accepted in IDLE.
REQ-032 resetn low during beat 1 -> all valids 0 that cycle, IDLE after release, no done.
REQ-033 With DCACHE_WB_PARALLEL_AW_EN, aw_ready delayed 5 cycles while w_ready=1 -> all 4 beats complete first, B entered only after AW accepted.
